// File: rtl/bconv_ex_sched_pkg.sv
// Shared RNS types for the fastBConvEx scheduler and the FSM state encoding.
package bconv_ex_sched_pkg;

  localparam int unsigned RESIDUE_W     = 32;
  localparam int unsigned N_SLOTS       = 2;
  localparam int unsigned B_BASIS_LEN   = 2;
  localparam int unsigned BBa_BASIS_LEN = B_BASIS_LEN + 1;
  localparam int unsigned q_BASIS_LEN   = 3;

  typedef logic [RESIDUE_W-1:0] rns_residue_t;

  // B limbs occupy the low indices, the single Ba limb is the last one.
  typedef rns_residue_t [N_SLOTS-1:0][BBa_BASIS_LEN-1:0] bba_poly_t;
  typedef rns_residue_t [N_SLOTS-1:0][q_BASIS_LEN-1:0]   q_poly_t;

  typedef enum logic [1:0] {
    IDLE,
    LAUNCH,
    WAIT,
    RESP
  } bconv_sched_state_t;

endpackage

// File: rtl/bconv_ex_sched_if.sv
// Request, datapath and response signals of the BConvEx scheduler.
interface bconv_ex_sched_if
  import bconv_ex_sched_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ID_W    = $clog2(NUM_REQ)
);

  logic      [NUM_REQ-1:0] req_valid;
  logic      [NUM_REQ-1:0] req_ready;
  bba_poly_t [NUM_REQ-1:0] req_poly;

  logic                    conv_in_valid;
  bba_poly_t               conv_in_poly;
  logic                    conv_out_valid;
  q_poly_t                 conv_out_poly;

  logic                    rsp_valid;
  logic                    rsp_ready;
  logic      [ID_W-1:0]    rsp_id;
  q_poly_t                 rsp_poly;

  logic                    busy;
  logic                    err_timeout;

  modport master (
    input  req_valid, req_poly, conv_out_valid, conv_out_poly, rsp_ready,
    output req_ready, conv_in_valid, conv_in_poly, rsp_valid, rsp_id, rsp_poly,
           busy, err_timeout
  );

  modport slave (
    output req_valid, req_poly, conv_out_valid, conv_out_poly, rsp_ready,
    input  req_ready, conv_in_valid, conv_in_poly, rsp_valid, rsp_id, rsp_poly,
           busy, err_timeout
  );

endinterface

// File: rtl/bconv_ex_sched_rr_arbiter.sv
// Combinational round-robin arbiter: grants the first valid requester at or after rr_ptr.
module rr_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ID_W    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_valid,
  input  logic [ID_W-1:0]    rr_ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    gnt_id
);

  logic [ID_W-1:0] idx;
  logic            found;

  always_comb begin
    grant  = '0;
    gnt_id = '0;
    idx    = '0;
    found  = 1'b0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      idx = ID_W'((32'(rr_ptr) + i) % NUM_REQ);
      if (!found && req_valid[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        gnt_id     = idx;
      end
    end
  end

endmodule

// File: rtl/bconv_ex_sched.sv
// Shares one fastBConvEx B+Ba->q datapath between NUM_REQ requesters, one operation in flight,
// with round-robin arbitration, a launch/done watchdog and an id-tagged registered response.
module bconv_ex_sched
  import bconv_ex_sched_pkg::*;
#(
  parameter int unsigned NUM_REQ     = 4,
  parameter int unsigned TIMEOUT_CYC = 1024,
  parameter int unsigned ID_W        = $clog2(NUM_REQ)
) (
  input  logic             clk,
  input  logic             reset,
  bconv_ex_sched_if.master bus
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC + 1);

  bconv_sched_state_t state_q, state_d;
  logic [ID_W-1:0]    rr_ptr_q, rr_ptr_d;
  logic [ID_W-1:0]    cur_id_q, cur_id_d;
  logic [ID_W-1:0]    rsp_id_q, rsp_id_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               err_q, err_d;
  bba_poly_t          op_q, op_d;
  q_poly_t            rsp_poly_q, rsp_poly_d;

  logic [NUM_REQ-1:0] grant;
  logic [ID_W-1:0]    gnt_id;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_arb (
    .req_valid (bus.req_valid),
    .rr_ptr    (rr_ptr_q),
    .grant     (grant),
    .gnt_id    (gnt_id)
  );

  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    cur_id_d   = cur_id_q;
    rsp_id_d   = rsp_id_q;
    cnt_d      = cnt_q;
    err_d      = err_q;
    op_d       = op_q;
    rsp_poly_d = rsp_poly_q;
    unique case (state_q)
      IDLE: begin
        if (|grant) begin
          op_d     = bus.req_poly[gnt_id];
          cur_id_d = gnt_id;
          rr_ptr_d = (gnt_id == ID_W'(NUM_REQ - 1)) ? '0 : gnt_id + ID_W'(1);
          state_d  = LAUNCH;
        end
      end
      LAUNCH: begin
        cnt_d   = '0;
        state_d = WAIT;
      end
      WAIT: begin
        cnt_d = cnt_q + CNT_W'(1);
        // A done arriving on the expiry cycle is still a valid result.
        if (bus.conv_out_valid) begin
          rsp_poly_d = bus.conv_out_poly;
          rsp_id_d   = cur_id_q;
          state_d    = RESP;
        end else if (cnt_d == CNT_W'(TIMEOUT_CYC)) begin
          err_d      = 1'b1;
          rsp_poly_d = '0;
          rsp_id_d   = cur_id_q;
          state_d    = RESP;
        end
      end
      RESP: begin
        if (bus.rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      rr_ptr_q   <= '0;
      cur_id_q   <= '0;
      rsp_id_q   <= '0;
      cnt_q      <= '0;
      err_q      <= 1'b0;
      op_q       <= '0;
      rsp_poly_q <= '0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      cur_id_q   <= cur_id_d;
      rsp_id_q   <= rsp_id_d;
      cnt_q      <= cnt_d;
      err_q      <= err_d;
      op_q       <= op_d;
      rsp_poly_q <= rsp_poly_d;
    end
  end

  // Ready is masked during reset so no request is accepted into a state about to be cleared.
  assign bus.req_ready     = (state_q == IDLE && !reset) ? grant : '0;
  assign bus.conv_in_valid = (state_q == LAUNCH);
  assign bus.conv_in_poly  = op_q;
  assign bus.rsp_valid     = (state_q == RESP);
  assign bus.rsp_id        = rsp_id_q;
  assign bus.rsp_poly      = rsp_poly_q;
  assign bus.busy          = (state_q != IDLE);
  assign bus.err_timeout   = err_q;

endmodule

// File: tb/tb_bconv_ex_sched.sv
// Directed bench for bconv_ex_sched: table of arbitration/latency transactions plus
// hand-written timeout, reset-in-WAIT and spurious-done sequences.
module tb_bconv_ex_sched;
  import bconv_ex_sched_pkg::*;

  localparam int unsigned NREQ = 4;
  localparam int unsigned TO   = 16;

  logic clk;
  logic reset;

  bconv_ex_sched_if #(.NUM_REQ(NREQ), .ID_W(2)) bus ();

  bconv_ex_sched #(
    .NUM_REQ     (NREQ),
    .TIMEOUT_CYC (TO),
    .ID_W        (2)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks;
  int n_fail;
  int n_launch;
  logic exp_err;
  bba_poly_t poly_tbl [NREQ];
  q_poly_t last_q;

  always @(posedge clk) if (bus.conv_in_valid) n_launch <= n_launch + 1;

  typedef struct {
    logic [3:0]  valid;
    logic [3:0]  exp_grant;
    int unsigned lat;
    int unsigned hold;
  } vec_t;

  vec_t tbl [14];

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Stand-in for the conversion datapath: any deterministic function of the operand.
  function automatic q_poly_t dp_model(input bba_poly_t p);
    q_poly_t r;
    for (int s = 0; s < N_SLOTS; s++)
      for (int j = 0; j < q_BASIS_LEN; j++)
        r[s][j] = p[s][j % BBa_BASIS_LEN] ^ (32'hD00D_0000 | 32'(j));
    return r;
  endfunction

  // Entered and left at a negedge with the DUT in IDLE.
  task automatic run_txn(input logic [3:0] valid, input logic [3:0] exp_g,
                         input int unsigned lat, input int unsigned hold);
    int g;
    int base;
    q_poly_t exp_q;
    g = 0;
    bus.req_valid = valid;
    #1;
    chk("req_ready", bus.req_ready, exp_g);
    chk("busy_idle", bus.busy, 0);
    if (exp_g == 4'b0000) begin
      @(negedge clk);
      chk("req_ready_none", bus.req_ready, 0);
      chk("busy_none", bus.busy, 0);
      return;
    end
    for (int i = 0; i < 4; i++) if (exp_g[i]) g = i;
    exp_q = dp_model(poly_tbl[g]);
    base  = n_launch;
    @(negedge clk);
    bus.req_valid = valid & ~exp_g;
    chk("launch", bus.conv_in_valid, 1);
    chk("busy_launch", bus.busy, 1);
    chk("req_ready_launch", bus.req_ready, 0);
    chk("conv_in_poly", bus.conv_in_poly, poly_tbl[g]);
    for (int unsigned k = 1; k <= lat; k++) begin
      @(negedge clk);
      chk("launch_once", bus.conv_in_valid, 0);
      chk("rsp_early", bus.rsp_valid, 0);
      chk("busy_wait", bus.busy, 1);
      if (k == lat) begin
        bus.conv_out_valid = 1'b1;
        bus.conv_out_poly  = dp_model(poly_tbl[g]);
      end
    end
    @(negedge clk);
    bus.conv_out_valid = 1'b0;
    for (int unsigned h = 0; h < hold; h++) begin
      chk("hold_rsp_valid", bus.rsp_valid, 1);
      chk("hold_rsp_poly", bus.rsp_poly, exp_q);
      chk("hold_req_ready", bus.req_ready, 0);
      chk("hold_no_launch", bus.conv_in_valid, 0);
      bus.conv_out_valid = 1'b1;
      bus.conv_out_poly  = {(N_SLOTS*q_BASIS_LEN){32'hDEAD_BEEF}};
      @(negedge clk);
    end
    bus.conv_out_valid = 1'b0;
    chk("rsp_valid", bus.rsp_valid, 1);
    chk("rsp_id", bus.rsp_id, g);
    chk("rsp_poly", bus.rsp_poly, exp_q);
    chk("err_timeout", bus.err_timeout, exp_err);
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    chk("rsp_done", bus.rsp_valid, 0);
    chk("busy_done", bus.busy, 0);
    chk("launch_count", n_launch - base, 1);
    last_q = exp_q;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got stuck expected finish");
    $fatal(1);
  end

  initial begin
    n_checks = 0;
    n_fail   = 0;
    n_launch = 0;
    exp_err  = 1'b0;
    reset    = 1'b0;
    for (int r = 0; r < NREQ; r++)
      for (int s = 0; s < N_SLOTS; s++)
        for (int l = 0; l < BBa_BASIS_LEN; l++)
          poly_tbl[r][s][l] = {8'(r + 1), 8'(s), 8'(l), 8'h5A};
    poly_tbl[2][0][0] = 32'd5;
    poly_tbl[2][0][1] = 32'd7;
    poly_tbl[2][0][2] = 32'd3;
    for (int r = 0; r < NREQ; r++) bus.req_poly[r] = poly_tbl[r];
    bus.req_valid      = '0;
    bus.conv_out_valid = 1'b0;
    bus.conv_out_poly  = '0;
    bus.rsp_ready      = 1'b0;
    last_q             = '0;

    // rr_ptr after each row: 1,2,3,0,1,3,1,3,2,0,0,2,3,1
    tbl[0]  = '{4'b1111, 4'b0001, 6,  0};
    tbl[1]  = '{4'b1111, 4'b0010, 1,  0};
    tbl[2]  = '{4'b1111, 4'b0100, 6,  10};
    tbl[3]  = '{4'b1111, 4'b1000, 2,  0};
    tbl[4]  = '{4'b1111, 4'b0001, 3,  0};
    tbl[5]  = '{4'b0100, 4'b0100, 6,  0};
    tbl[6]  = '{4'b0001, 4'b0001, 2,  0};
    tbl[7]  = '{4'b1100, 4'b0100, 1,  0};
    tbl[8]  = '{4'b0110, 4'b0010, 4,  0};
    tbl[9]  = '{4'b1001, 4'b1000, 2,  0};
    tbl[10] = '{4'b0000, 4'b0000, 1,  0};
    tbl[11] = '{4'b1010, 4'b0010, 3,  0};
    tbl[12] = '{4'b1111, 4'b0100, 16, 0};
    tbl[13] = '{4'b0011, 4'b0001, 15, 0};

    #2 reset = 1'b1;
    bus.req_valid = 4'b1111;
    #1;
    chk("rst_req_ready", bus.req_ready, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_rsp_valid", bus.rsp_valid, 0);
    chk("rst_launch", bus.conv_in_valid, 0);
    chk("rst_err", bus.err_timeout, 0);
    chk("rst_rsp_poly", bus.rsp_poly, 0);
    chk("rst_conv_in_poly", bus.conv_in_poly, 0);
    repeat (3) @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 14; i++) run_txn(tbl[i].valid, tbl[i].exp_grant, tbl[i].lat, tbl[i].hold);

    // Spurious done while idle.
    bus.req_valid = '0;
    for (int i = 0; i < 3; i++) begin
      bus.conv_out_valid = 1'b1;
      bus.conv_out_poly  = {(N_SLOTS*q_BASIS_LEN){32'hBAD0_0BAD}};
      @(negedge clk);
      chk("idle_spur_rsp_valid", bus.rsp_valid, 0);
      chk("idle_spur_busy", bus.busy, 0);
      chk("idle_spur_rsp_poly", bus.rsp_poly, last_q);
    end
    bus.conv_out_valid = 1'b0;

    // Watchdog: launch in cycle L, no done; expiry decided in cycle L+16.
    bus.req_valid = 4'b1000;
    #1 chk("to_req_ready", bus.req_ready, 4'b1000);
    @(negedge clk);
    bus.req_valid = '0;
    chk("to_launch", bus.conv_in_valid, 1);
    for (int k = 1; k <= TO; k++) begin
      @(negedge clk);
      chk("to_err_early", bus.err_timeout, 0);
      chk("to_rsp_early", bus.rsp_valid, 0);
    end
    @(negedge clk);
    chk("to_err", bus.err_timeout, 1);
    chk("to_rsp_valid", bus.rsp_valid, 1);
    chk("to_rsp_poly", bus.rsp_poly, 0);
    chk("to_rsp_id", bus.rsp_id, 3);
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    chk("to_err_sticky", bus.err_timeout, 1);
    chk("to_idle", bus.busy, 0);
    exp_err = 1'b1;
    run_txn(4'b0010, 4'b0010, 4, 0);

    // Asynchronous reset in WAIT, then a late done must be ignored.
    bus.req_valid = 4'b0100;
    #1 chk("rw_req_ready", bus.req_ready, 4'b0100);
    @(negedge clk);
    bus.req_valid = 4'b1011;
    chk("rw_launch", bus.conv_in_valid, 1);
    repeat (2) @(negedge clk);
    @(posedge clk);
    #3 reset = 1'b1;
    #1;
    chk("rw_busy", bus.busy, 0);
    chk("rw_req_ready0", bus.req_ready, 0);
    chk("rw_rsp_valid", bus.rsp_valid, 0);
    chk("rw_launch0", bus.conv_in_valid, 0);
    chk("rw_err_cleared", bus.err_timeout, 0);
    chk("rw_conv_in_poly", bus.conv_in_poly, 0);
    chk("rw_rsp_poly", bus.rsp_poly, 0);
    chk("rw_rsp_id", bus.rsp_id, 0);
    @(negedge clk);
    bus.req_valid = '0;
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bus.conv_out_valid = 1'b1;
      bus.conv_out_poly  = {(N_SLOTS*q_BASIS_LEN){32'h1A7E_D0E5}};
      @(negedge clk);
      chk("late_done_rsp", bus.rsp_valid, 0);
      chk("late_done_busy", bus.busy, 0);
    end
    bus.conv_out_valid = 1'b0;
    exp_err = 1'b0;
    run_txn(4'b1111, 4'b0001, 5, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
